sd_spi_burst_ctrl: RTL and testbench

Parametrised SPI master for the SD card. It is the successor to the single-byte "read-to-trigger" SPI port in the cartridge CPLD. The host-side address decoder turns 68k reads into one-cycle command strobes. This block runs the SPI shifter with runtime-selectable dividers, supports card lock, CS and speed control, and performs hardware burst reads of BURST_LEN bytes into a prefetch FIFO. The 68k pops burst bytes at bus speed instead of polling per byte.

---
 rtl/sd_spi_pkg.sv | 22 ++
 rtl/sd_byte_fifo.sv | 57 +++++
 rtl/sd_spi_burst_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_sd_spi_burst_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared opcodes, shifter states and constants for the SD-card SPI burst controller.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    SD_OP_SEND      = 3'd0,
    SD_OP_SET_CS    = 3'd1,
    SD_OP_SET_SPEED = 3'd2,
    SD_OP_SET_LOCK  = 3'd3,
    SD_OP_BURST     = 3'd4,
    SD_OP_ABORT     = 3'd5
  } sd_op_e;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_DONE  = 2'd2
  } sh_state_e;

  localparam logic [7:0] SD_IDLE_BYTE    = 8'hFF;
  localparam int         SD_SECTOR_BYTES = 512;

endpackage

// File: rtl/sd_byte_fifo.sv
// Small synchronous FIFO with a combinational head, used as the burst prefetch buffer.
module sd_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [W-1:0]           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // A pop frees the head slot in the same cycle, so push+pop is legal when full.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/sd_spi_burst_ctrl.sv
// SPI mode-0 master for the SD card: single-byte SEND, CS/speed/lock control and
// hardware sector bursts of 0xFF bytes whose replies land in a prefetch FIFO.
module sd_spi_burst_ctrl
  import sd_spi_pkg::*;
#(
  parameter int SLOW_DIV   = 30,
  parameter int FAST_DIV   = 0,
  parameter int DIV_W      = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = SD_SECTOR_BYTES,
  parameter int CNT_W      = 10
) (
  input  logic       CLOCK_50,
  input  logic       nRESET,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_arg,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       fifo_empty,
  output logic       burst_active,
  output logic       locked,
  output logic       err,
  output logic       SPI_CS,
  output logic       SPI_CLK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO
);

  localparam int                CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0]  C_SLOW  = DIV_W'(SLOW_DIV);
  localparam logic [DIV_W-1:0]  C_FAST  = DIV_W'(FAST_DIV);
  localparam logic [CNT_W-1:0]  C_BURST = CNT_W'(BURST_LEN);

  sh_state_e        r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_phase;
  logic [7:0]       r_tx_sr;
  logic [7:0]       r_rx_sr;
  logic [7:0]       r_last_rx;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_cs;
  logic             r_fast;
  logic             r_locked;
  logic             r_err;
  logic             r_burst;
  logic [CNT_W-1:0] r_burst_cnt;

  logic             w_busy;
  logic             w_burst_active;
  logic             w_abort;
  logic             w_send_ok;
  logic             w_burst_ok;
  logic             w_err_set;
  logic             w_pop_ok;
  logic             w_push;
  logic             w_room_done;
  logic             w_room_idle;
  logic             w_burst_more;
  logic             w_start;
  logic [7:0]       w_start_byte;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [7:0]       w_fifo_head;
  logic [CW-1:0]    w_fifo_count;

  // The burst counter is decremented on leaving SHIFT, so it already reads zero
  // in the DONE cycle of the last byte, which is where burst_active must drop.
  assign w_burst_active = r_burst && (r_burst_cnt != '0);
  assign w_busy         = (r_state == SH_SHIFT) || w_burst_active;

  assign w_abort    = cmd_valid && (cmd_op == SD_OP_ABORT);
  assign w_send_ok  = cmd_valid && (cmd_op == SD_OP_SEND)  && !r_locked && !w_busy;
  assign w_burst_ok = cmd_valid && (cmd_op == SD_OP_BURST) && !r_locked && !w_busy;
  assign w_err_set  = (cmd_valid && (cmd_op == SD_OP_SEND)  && !r_locked && w_busy)
                   || (cmd_valid && (cmd_op == SD_OP_BURST) && (r_locked || w_busy))
                   || (pop && w_fifo_empty);

  assign w_pop_ok = pop && !w_fifo_empty && !w_abort;
  assign w_push   = (r_state == SH_DONE) && r_burst;

  // In DONE the FIFO is about to take one byte; the next byte may start only if a
  // slot is still free after that push.
  assign w_room_done  = (w_fifo_count < CW'(FIFO_DEPTH - 1)) || w_pop_ok;
  assign w_room_idle  = !w_fifo_full || w_pop_ok;
  assign w_burst_more = r_burst && (r_burst_cnt != '0)
                     && (((r_state == SH_DONE) && w_room_done)
                      || ((r_state == SH_IDLE) && w_room_idle));
  assign w_start      = !w_abort && (w_send_ok || w_burst_ok || w_burst_more);
  assign w_start_byte = w_send_ok ? cmd_arg : SD_IDLE_BYTE;

  always_ff @(posedge CLOCK_50 or negedge nRESET) begin
    if (!nRESET) begin
      r_cs     <= 1'b1;
      r_fast   <= 1'b0;
      r_locked <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      if (cmd_valid) begin
        case (cmd_op)
          SD_OP_SET_CS:    r_cs   <= cmd_arg[0];
          SD_OP_SET_SPEED: r_fast <= cmd_arg[0];
          SD_OP_SET_LOCK:  if (!w_busy) r_locked <= cmd_arg[0];
          default: ;
        endcase
      end
      if (w_abort)        r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nRESET) begin
    if (!nRESET) begin
      r_state     <= SH_IDLE;
      r_div       <= C_SLOW;
      r_div_cnt   <= '0;
      r_phase     <= '0;
      r_tx_sr     <= SD_IDLE_BYTE;
      r_rx_sr     <= SD_IDLE_BYTE;
      r_last_rx   <= SD_IDLE_BYTE;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b1;
      r_burst     <= 1'b0;
      r_burst_cnt <= '0;
    end else if (w_abort) begin
      r_state     <= SH_IDLE;
      r_div_cnt   <= '0;
      r_phase     <= '0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b1;
      r_burst     <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        SH_SHIFT: begin
          if (r_div_cnt == r_div) begin
            r_div_cnt <= '0;
            r_phase   <= r_phase + 4'd1;
            r_sclk    <= ~r_sclk;
            if (!r_phase[0]) begin
              r_rx_sr <= {r_rx_sr[6:0], SPI_MISO};
            end else if (r_phase == 4'd15) begin
              r_mosi  <= 1'b1;
              r_state <= SH_DONE;
              if (r_burst) r_burst_cnt <= r_burst_cnt - CNT_W'(1);
            end else begin
              r_mosi  <= r_tx_sr[6];
              r_tx_sr <= {r_tx_sr[6:0], 1'b0};
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        SH_DONE: begin
          if (!r_burst) r_last_rx <= r_rx_sr;
          if (r_burst_cnt == '0) r_burst <= 1'b0;
          r_state <= SH_IDLE;
        end
        default: ;
      endcase
      // A new burst may be accepted in the DONE cycle of the previous one.
      if (w_burst_ok) begin
        r_burst     <= 1'b1;
        r_burst_cnt <= C_BURST;
      end
      if (w_start) begin
        r_state   <= SH_SHIFT;
        r_div     <= r_fast ? C_FAST : C_SLOW;
        r_div_cnt <= '0;
        r_phase   <= '0;
        r_sclk    <= 1'b0;
        r_tx_sr   <= w_start_byte;
        r_mosi    <= w_start_byte[7];
      end
    end
  end

  sd_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .i_clk   (CLOCK_50),
    .i_rst_n (nRESET),
    .i_push  (w_push),
    .i_data  (r_rx_sr),
    .i_pop   (pop && !w_abort),
    .i_flush (w_abort),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  assign rd_data      = w_fifo_empty ? r_last_rx : w_fifo_head;
  assign busy         = w_busy;
  assign fifo_empty   = w_fifo_empty;
  assign burst_active = w_burst_active;
  assign locked       = r_locked;
  assign err          = r_err;
  assign SPI_CS       = r_cs;
  assign SPI_CLK      = r_sclk;
  assign SPI_MOSI     = r_mosi;

endmodule

// File: tb/tb_sd_spi_burst_ctrl.sv
// Randomised self-checking bench for sd_spi_burst_ctrl with a simple SPI slave model.
module tb_sd_spi_burst_ctrl;
  import sd_spi_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       nRESET;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       pop;
  logic [7:0] rd_data;
  logic       busy, fifo_empty, burst_active, locked, err;
  logic       SPI_CS, SPI_CLK, SPI_MOSI, SPI_MISO;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  sd_spi_burst_ctrl dut (
    .CLOCK_50     (CLOCK_50),
    .nRESET       (nRESET),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .pop          (pop),
    .rd_data      (rd_data),
    .busy         (busy),
    .fifo_empty   (fifo_empty),
    .burst_active (burst_active),
    .locked       (locked),
    .err          (err),
    .SPI_CS       (SPI_CS),
    .SPI_CLK      (SPI_CLK),
    .SPI_MOSI     (SPI_MOSI),
    .SPI_MISO     (SPI_MISO)
  );

  // Line monitor: counts SCLK rises, collects MOSI at each rise, times the edges.
  int         sclk_rises = 0;
  logic [7:0] mosi_sr = 8'h00;
  time        t_rise = 0;
  time        t_fall = 0;
  always @(posedge SPI_CLK) begin
    sclk_rises <= sclk_rises + 1;
    mosi_sr    <= {mosi_sr[6:0], SPI_MOSI};
    t_rise     <= $time;
  end
  always @(negedge SPI_CLK) t_fall <= $time;

  // Slave model: serves a byte stream MSB first, advancing one bit per SCLK rise.
  int         miso_base  = 0;
  logic [7:0] miso_start = 8'hFF;
  bit         miso_incr  = 1'b0;
  always_comb begin
    int         k;
    logic [7:0] b;
    k = sclk_rises - miso_base;
    b = miso_incr ? (miso_start + 8'(k / 8)) : miso_start;
    SPI_MISO = b[3'(7 - (k % 8))];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] arg);
    @(negedge CLOCK_50);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    $display("cmd op=%0d arg=0x%02h busy=%0b err=%0b", op, arg, busy, err);
  endtask

  task automatic wait_busy_low(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic pop_once();
    @(negedge CLOCK_50);
    pop = 1'b1;
    @(negedge CLOCK_50);
    pop = 1'b0;
  endtask

  task automatic set_miso_const(input logic [7:0] b);
    miso_incr  = 1'b0;
    miso_start = b;
    miso_base  = sclk_rises;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_cs"},    32'(SPI_CS), 32'd1);
    check_val({pfx, "_clk"},   32'(SPI_CLK), 32'd0);
    check_val({pfx, "_mosi"},  32'(SPI_MOSI), 32'd1);
    check_val({pfx, "_lock"},  32'(locked), 32'd1);
    check_val({pfx, "_busy"},  32'(busy), 32'd0);
    check_val({pfx, "_bact"},  32'(burst_active), 32'd0);
    check_val({pfx, "_empty"}, 32'(fifo_empty), 32'd1);
    check_val({pfx, "_err"},   32'(err), 32'd0);
    check_val({pfx, "_rd"},    32'(rd_data), 32'hFF);
  endtask

  initial begin
    int         n;
    int         r0;
    int         npop;
    int         cyc;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] last_rx_model;
    logic [7:0] exp_b;

    nRESET    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = 8'h00;
    pop       = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_reset_outputs("rst");
    nRESET = 1'b1;
    @(negedge CLOCK_50);

    // SEND while locked: silently ignored, no clocks.
    r0 = sclk_rises;
    send_cmd(SD_OP_SEND, 8'h12);
    repeat (40) @(negedge CLOCK_50);
    check_val("locked_send_sclk", 32'(sclk_rises - r0), 32'd0);
    check_val("locked_send_err", 32'(err), 32'd0);
    check_val("locked_send_busy", 32'(busy), 32'd0);

    send_cmd(SD_OP_SET_LOCK, 8'h00);
    check_val("unlock", 32'(locked), 32'd0);
    send_cmd(SD_OP_SET_CS, 8'h00);
    check_val("cs_low", 32'(SPI_CS), 32'd0);

    // Slow SEND 0x40 with the slave returning 0xA5.
    set_miso_const(8'hA5);
    r0 = sclk_rises;
    send_cmd(SD_OP_SEND, 8'h40);
    wait_busy_low(n);
    check_val("slow_busy_cycles", 32'(n), 32'd496);
    check_val("slow_rises", 32'(sclk_rises - r0), 32'd8);
    check_val("slow_mosi", 32'(mosi_sr), 32'h40);
    check_val("slow_half_period", 32'((t_fall - t_rise) / 10), 32'd31);
    @(negedge CLOCK_50);
    check_val("slow_last_rx", 32'(rd_data), 32'hA5);
    $display("slow send tx=0x40 rx=0x%02h busy_cycles=%0d", rd_data, n);

    // Commands during a byte: lock ignored, SEND/BURST rejected with err.
    send_cmd(SD_OP_SEND, 8'h00);
    repeat (20) @(negedge CLOCK_50);
    send_cmd(SD_OP_SET_LOCK, 8'h01);
    check_val("lock_while_busy", 32'(locked), 32'd0);
    check_val("err_before_busy_send", 32'(err), 32'd0);
    send_cmd(SD_OP_SEND, 8'h33);
    check_val("send_busy_err", 32'(err), 32'd1);
    send_cmd(SD_OP_ABORT, 8'h00);
    check_val("abort1_err", 32'(err), 32'd0);
    check_val("abort1_busy", 32'(busy), 32'd0);
    send_cmd(SD_OP_SEND, 8'h00);
    repeat (20) @(negedge CLOCK_50);
    send_cmd(SD_OP_BURST, 8'h00);
    check_val("burst_busy_err", 32'(err), 32'd1);
    check_val("burst_busy_ignored", 32'(burst_active), 32'd0);
    send_cmd(SD_OP_ABORT, 8'h00);
    check_val("abort2_clk", 32'(SPI_CLK), 32'd0);
    send_cmd(7, 8'h01);
    check_val("reserved_no_err", 32'(err), 32'd0);

    // Fast random SENDs: reply equals the slave byte, 16 cycles per byte.
    send_cmd(SD_OP_SET_SPEED, 8'h01);
    last_rx_model = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      tx = 8'($urandom);
      rx = 8'($urandom);
      set_miso_const(rx);
      send_cmd(SD_OP_SEND, tx);
      wait_busy_low(n);
      @(negedge CLOCK_50);
      last_rx_model = rx;
      check_val("fast_busy_cycles", 32'(n), 32'd16);
      check_val("fast_mosi", 32'(mosi_sr), 32'(tx));
      check_val("fast_rx", 32'(rd_data), 32'(last_rx_model));
      $display("fast send tx=0x%02h rx=0x%02h expect=0x%02h", tx, rd_data, rx);
    end

    // Burst with no pops: fills the FIFO and stalls.
    miso_incr  = 1'b1;
    miso_start = 8'h00;
    miso_base  = sclk_rises;
    r0 = sclk_rises;
    send_cmd(SD_OP_BURST, 8'h00);
    repeat (400) @(negedge CLOCK_50);
    check_val("stall_rises", 32'(sclk_rises - r0), 32'd128);
    check_val("stall_clk_low", 32'(SPI_CLK), 32'd0);
    check_val("stall_not_empty", 32'(fifo_empty), 32'd0);
    check_val("stall_bact", 32'(burst_active), 32'd1);
    check_val("stall_head", 32'(rd_data), 32'h00);
    repeat (100) @(negedge CLOCK_50);
    check_val("stall_holds", 32'(sclk_rises - r0), 32'd128);

    // Drain with random pop gaps; data must arrive as the slave stream in order.
    exp_b = 8'h00;
    npop  = 0;
    cyc   = 0;
    while (npop < 512 && cyc < 30000) begin
      @(negedge CLOCK_50);
      pop = 1'b0;
      cyc++;
      if (!fifo_empty && $urandom_range(3) != 0) begin
        check_val("burst_data", 32'(rd_data), 32'(exp_b));
        pop   = 1'b1;
        exp_b = exp_b + 8'd1;
        npop++;
      end
    end
    @(negedge CLOCK_50);
    pop = 1'b0;
    check_val("burst_count", 32'(npop), 32'd512);
    check_val("burst_done_bact", 32'(burst_active), 32'd0);
    check_val("burst_done_empty", 32'(fifo_empty), 32'd1);
    check_val("burst_done_busy", 32'(busy), 32'd0);
    $display("burst drained %0d bytes in %0d cycles", npop, cyc);

    // Pop on empty: err and last_rx visible.
    check_val("pre_pop_err", 32'(err), 32'd0);
    pop_once();
    check_val("empty_pop_err", 32'(err), 32'd1);
    check_val("empty_pop_rd", 32'(rd_data), 32'(last_rx_model));

    // ABORT mid-burst.
    send_cmd(SD_OP_BURST, 8'h00);
    repeat ($urandom_range(70, 40)) @(negedge CLOCK_50);
    send_cmd(SD_OP_ABORT, 8'h00);
    check_val("abort_clk", 32'(SPI_CLK), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_empty", 32'(fifo_empty), 32'd1);
    check_val("abort_err", 32'(err), 32'd0);
    check_val("abort_cs", 32'(SPI_CS), 32'd0);
    check_val("abort_mosi", 32'(SPI_MOSI), 32'd1);

    // Asynchronous reset mid-burst, away from any clock edge.
    pop_once();
    send_cmd(SD_OP_BURST, 8'h00);
    repeat ($urandom_range(90, 30)) @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #2;
    nRESET = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge CLOCK_50);
    nRESET = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
